// File: rtl/ps2_pkg.sv
// Shared constants, sequence buffer sizing and sequencer states for the PS/2 key sender.
// PS2_PAUSE_KEY_EN widens the sequence buffer to hold the 8-byte Pause sequence.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

`ifdef PS2_PAUSE_KEY_EN
    localparam int SEQ_IDX_W = 3;
`else
    localparam int SEQ_IDX_W = 2;
`endif
    localparam int SEQ_SLOTS = 1 << SEQ_IDX_W;
    localparam int LEN_W     = SEQ_IDX_W + 1;

    localparam logic [7:0] PAUSE_SEQ [0:7] = '{PS2_E1, 8'h14, 8'h77, PS2_E1,
                                               PS2_F0, 8'h14, PS2_F0, 8'h77};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FRAME,
        ST_GAP,
        ST_WAIT_INH
    } seq_state_t;

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-slot PS/2 device frame: start, 8 data LSB first, odd parity, stop.
// Each slot is CLK_DIV cycles with the clock released, then CLK_DIV cycles with it low.
module ps2_frame_tx #(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_byte,
    input  logic       start,
    input  logic       abort,
    output logic       done,
    output logic       stop_slot,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int HALF_W = $clog2(CLK_DIV);
    localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(CLK_DIV - 1);

    logic              active_reg;
    logic              low_reg;
    logic              ps2_clk_reg;
    logic              ps2_data_reg;
    logic [HALF_W-1:0] half_reg;
    logic [3:0]        slot_reg;
    logic [9:0]        shift_reg;
    logic              half_end;

    assign half_end  = (half_reg == HALF_MAX);
    assign done      = active_reg && low_reg && half_end && (slot_reg == 4'd10);
    assign stop_slot = active_reg && (slot_reg == 4'd10);
    assign ps2_clk   = ps2_clk_reg;
    assign ps2_data  = ps2_data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_reg   <= 1'b0;
            low_reg      <= 1'b0;
            half_reg     <= '0;
            slot_reg     <= '0;
            shift_reg    <= '0;
            ps2_clk_reg  <= 1'b1;
            ps2_data_reg <= 1'b1;
        end else if (abort) begin
            active_reg   <= 1'b0;
            low_reg      <= 1'b0;
            half_reg     <= '0;
            slot_reg     <= '0;
            ps2_clk_reg  <= 1'b1;
            ps2_data_reg <= 1'b1;
        end else if (start) begin
            // Start bit goes out immediately; the shifter holds data, parity and stop.
            active_reg   <= 1'b1;
            low_reg      <= 1'b0;
            half_reg     <= '0;
            slot_reg     <= '0;
            shift_reg    <= {1'b1, ~^tx_byte, tx_byte};
            ps2_clk_reg  <= 1'b1;
            ps2_data_reg <= 1'b0;
        end else if (active_reg) begin
            if (!half_end) begin
                half_reg <= half_reg + 1'b1;
            end else begin
                half_reg <= '0;
                if (!low_reg) begin
                    low_reg     <= 1'b1;
                    ps2_clk_reg <= 1'b0;
                end else begin
                    low_reg     <= 1'b0;
                    ps2_clk_reg <= 1'b1;
                    if (slot_reg == 4'd10) begin
                        active_reg   <= 1'b0;
                        slot_reg     <= '0;
                        ps2_data_reg <= 1'b1;
                    end else begin
                        slot_reg     <= slot_reg + 4'd1;
                        ps2_data_reg <= shift_reg[0];
                        shift_reg    <= {1'b1, shift_reg[9:1]};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_sender.sv
// Expands a raw set-2 key event into its E0/F0 byte sequence and sends it frame by frame,
// yielding to host inhibit. Define PS2_PAUSE_KEY_EN to map 9'h1FF onto the Pause sequence.
module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [8:0] key_code,
    input  logic       key_break,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       host_inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int GAP_W = $clog2(2 * CLK_DIV);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(2 * CLK_DIV - 1);

    seq_state_t       state_reg;
    logic [7:0]       seq_reg  [0:SEQ_SLOTS-1];
    logic [7:0]       seq_next [0:SEQ_SLOTS-1];
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] idx_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             key_ready_reg;
    logic             accept;
    logic             gap_end;
    logic             more;
    logic             tx_start;
    logic             tx_abort;
    logic             tx_done;
    logic             tx_stop_slot;
    logic [7:0]       tx_byte;

    assign accept    = key_valid && key_ready_reg;
    assign gap_end   = (state_reg == ST_GAP) && (gap_reg == GAP_MAX);
    assign more      = (idx_reg != len_reg);
    assign key_ready = key_ready_reg;
    assign busy      = ~key_ready_reg;

    always_comb begin
        seq_next = '{default: 8'h00};
        len_next = '0;
`ifdef PS2_PAUSE_KEY_EN
        if (key_code == 9'h1FF) begin
            // A Pause break has no bytes; it still passes through LOAD to stay busy one cycle.
            if (!key_break) begin
                for (int i = 0; i < 8; i++) begin
                    seq_next[i] = PAUSE_SEQ[i];
                end
                len_next = LEN_W'(8);
            end
        end else
`endif
        if (key_code[8] && key_break) begin
            seq_next[0] = PS2_E0;
            seq_next[1] = PS2_F0;
            seq_next[2] = key_code[7:0];
            len_next    = LEN_W'(3);
        end else if (key_code[8]) begin
            seq_next[0] = PS2_E0;
            seq_next[1] = key_code[7:0];
            len_next    = LEN_W'(2);
        end else if (key_break) begin
            seq_next[0] = PS2_F0;
            seq_next[1] = key_code[7:0];
            len_next    = LEN_W'(2);
        end else begin
            seq_next[0] = key_code[7:0];
            len_next    = LEN_W'(1);
        end
    end

    // The first byte is taken straight from the decoder so the start bit leaves on T+1.
    always_comb begin
        tx_start = 1'b0;
        tx_abort = 1'b0;
        tx_byte  = seq_reg[idx_reg[SEQ_IDX_W-1:0]];
        case (state_reg)
            ST_IDLE: begin
                tx_byte  = seq_next[0];
                tx_start = accept && (len_next != '0) && !host_inhibit;
            end
            ST_LOAD:     tx_start = more && !host_inhibit;
            ST_FRAME:    tx_abort = host_inhibit && !tx_stop_slot;
            ST_GAP:      tx_start = gap_end && more && !host_inhibit;
            ST_WAIT_INH: tx_start = !host_inhibit;
            default:     tx_start = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            seq_reg       <= '{default: 8'h00};
            len_reg       <= '0;
            idx_reg       <= '0;
            gap_reg       <= '0;
            key_ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        seq_reg       <= seq_next;
                        len_reg       <= len_next;
                        idx_reg       <= '0;
                        key_ready_reg <= 1'b0;
                        if (len_next == '0)    state_reg <= ST_LOAD;
                        else if (host_inhibit) state_reg <= ST_WAIT_INH;
                        else                   state_reg <= ST_FRAME;
                    end
                end
                ST_LOAD: begin
                    if (!more) begin
                        state_reg     <= ST_IDLE;
                        key_ready_reg <= 1'b1;
                    end else if (host_inhibit) begin
                        state_reg <= ST_WAIT_INH;
                    end else begin
                        state_reg <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    // An aborted byte keeps its index so the retry resends it whole.
                    if (tx_abort) begin
                        state_reg <= ST_WAIT_INH;
                    end else if (tx_done) begin
                        state_reg <= ST_GAP;
                        gap_reg   <= '0;
                        idx_reg   <= idx_reg + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_end) begin
                        gap_reg <= '0;
                        if (!more) begin
                            state_reg     <= ST_IDLE;
                            key_ready_reg <= 1'b1;
                        end else if (host_inhibit) begin
                            state_reg <= ST_WAIT_INH;
                        end else begin
                            state_reg <= ST_FRAME;
                        end
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                ST_WAIT_INH: begin
                    if (!host_inhibit) state_reg <= ST_FRAME;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    ps2_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_frame_tx (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_byte   (tx_byte),
        .start     (tx_start),
        .abort     (tx_abort),
        .done      (tx_done),
        .stop_slot (tx_stop_slot),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data)
    );

endmodule

// File: tb/tb_ps2_key_sender.sv
// Bench for ps2_key_sender: a PS/2 host model decodes frames on falling ps2_clk edges and a
// scoreboard compares them with byte sequences derived from the key event rules.
module tb_ps2_key_sender;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] key_code = '0;
    logic       key_break = 1'b0;
    logic       key_valid = 1'b0;
    logic       host_inhibit = 1'b0;
    logic       key_ready;
    logic       ps2_clk;
    logic       ps2_data;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    ps2_key_sender #(
        .CLK_DIV(D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .host_inhibit (host_inhibit),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: bytes the host must see for one accepted event.
    task automatic push_expected(input logic [8:0] code, input logic brk, output int n);
        logic [7:0] pause_bytes [0:7];
        pause_bytes = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        n = 0;
`ifdef PS2_PAUSE_KEY_EN
        if (code == 9'h1FF) begin
            if (!brk) begin
                for (int i = 0; i < 8; i++) exp_q.push_back(pause_bytes[i]);
                n = 8;
            end
            return;
        end
`endif
        if (code[8]) begin exp_q.push_back(8'hE0); n++; end
        if (brk)     begin exp_q.push_back(8'hF0); n++; end
        exp_q.push_back(code[7:0]);
        n++;
    endtask

    // Host model and scoreboard monitor.
    initial begin : host_model
        logic       prev;
        logic [3:0] cnt;
        logic [10:0] bits;
        logic [7:0] got;
        logic [7:0] want;
        prev = 1'b1;
        cnt  = 4'd0;
        bits = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt  = 4'd0;
                prev = 1'b1;
            end else begin
                if (host_inhibit && cnt > 4'd0 && cnt < 4'd10) cnt = 4'd0;
                if (prev && !ps2_clk) begin
                    bits[cnt] = ps2_data;
                    cnt = cnt + 4'd1;
                    if (cnt == 4'd11) begin
                        cnt = 4'd0;
                        got = bits[8:1];
                        $display("frame byte=%02h parity=%0d stop=%0d", got, bits[9], bits[10]);
                        check("start_bit", 32'(bits[0]), 32'd0);
                        check("parity", 32'(bits[9]), 32'(~^got));
                        check("stop_bit", 32'(bits[10]), 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_frame: got %02h want none", got);
                        end else begin
                            want = exp_q.pop_front();
                            check("frame_byte", 32'(got), 32'(want));
                        end
                    end
                end
                prev = ps2_clk;
            end
        end
    end

    task automatic offer(input logic [8:0] code, input logic brk, output int t, output int n);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!key_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_before_offer: got 0 want 1");
        end
        key_code  = code;
        key_break = brk;
        key_valid = 1'b1;
        t = cyc;
        push_expected(code, brk, n);
        $display("offer code=%03h break=%0d bytes=%0d", code, brk, n);
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic garbage_offers(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            key_code  = 9'($urandom_range(0, 511));
            key_break = 1'($urandom_range(0, 1));
            key_valid = 1'b1;
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_ready(input int t, input int exp_lat, input bit chk_edges);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            k = cyc - t;
            if (chk_edges) begin
                if (k == 1) begin
                    check("start_bit_t1", 32'(ps2_data), 32'd0);
                    check("ready_low_t1", 32'(key_ready), 32'd0);
                    check("busy_high_t1", 32'(busy), 32'd1);
                end
                if (k == D)     check("clk_high_before_fall", 32'(ps2_clk), 32'd1);
                if (k == D + 1) check("first_fall", 32'(ps2_clk), 32'd0);
            end
            if (key_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got 0 want 1");
        end else begin
            if (exp_lat >= 0) check("ready_latency", 32'(k), 32'(exp_lat));
            check("busy_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin : stimulus
        int t;
        int n;
        int bad;
        logic [8:0] code;
        logic brk;

        repeat (3) @(negedge clk);
        check("reset_ps2_clk", 32'(ps2_clk), 32'd1);
        check("reset_ps2_data", 32'(ps2_data), 32'd1);
        check("reset_key_ready", 32'(key_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        offer(9'h01C, 1'b0, t, n);
        wait_ready(t, 1 + 24 * n * D, 1'b1);

        offer(9'h175, 1'b1, t, n);
        wait_ready(t, 1 + 24 * n * D, 1'b1);

        offer(9'h000, 1'b0, t, n);
        wait_ready(t, 1 + 24 * n * D, 1'b1);

        // Inhibit pulse in slot 4 of the second (F0) byte.
        offer(9'h114, 1'b1, t, n);
        wait_until(t + 1 + 24 * D + 2 * D * 4 + 1);
        host_inhibit = 1'b1;
        @(negedge clk);
        check("abort_release_clk", 32'(ps2_clk), 32'd1);
        check("abort_release_data", 32'(ps2_data), 32'd1);
        repeat (2) @(negedge clk);
        host_inhibit = 1'b0;
        wait_ready(t, -1, 1'b0);

        // Inhibit held before acceptance.
        @(negedge clk);
        host_inhibit = 1'b1;
        offer(9'h029, 1'b0, t, n);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!ps2_clk || !ps2_data || key_ready) bad++;
        end
        check("inhibit_hold_released", 32'(bad), 32'd0);
        host_inhibit = 1'b0;
        @(negedge clk);
        check("start_after_inhibit", 32'(ps2_data), 32'd0);
        wait_ready(t, -1, 1'b0);

        // Reset during the low phase of slot 3.
        offer(9'h033, 1'b0, t, n);
        wait_until(t + 30);
        check("midframe_clk_low", 32'(ps2_clk), 32'd0);
        check("midframe_data_low", 32'(ps2_data), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_reset_clk", 32'(ps2_clk), 32'd1);
        check("async_reset_data", 32'(ps2_data), 32'd1);
        check("async_reset_ready", 32'(key_ready), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        offer(9'h05A, 1'b0, t, n);
        wait_ready(t, 1 + 24 * n * D, 1'b1);

        for (int r = 0; r < 16; r++) begin
            code = 9'($urandom_range(0, 511));
            brk  = 1'($urandom_range(0, 1));
`ifdef PS2_PAUSE_KEY_EN
            if (code == 9'h1FF) code = 9'h1FE;
`endif
            offer(code, brk, t, n);
            garbage_offers(6);
            wait_ready(t, 1 + 24 * n * D, 1'b0);
        end

`ifdef PS2_PAUSE_KEY_EN
        offer(9'h1FF, 1'b0, t, n);
        garbage_offers(8);
        wait_ready(t, 1 + 24 * n * D, 1'b0);
        offer(9'h1FF, 1'b1, t, n);
        wait_ready(t, 2, 1'b0);
`endif

        repeat (4 * D) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
